// File: rtl/reduccion_pkg.sv
// Shared definitions for the 32->16 signed narrowing unit.
package reduccion_pkg;

  localparam int ANCHO_PALABRA = 32;
  localparam int ANCHO_MEDIA   = 16;

  localparam logic [ANCHO_MEDIA-1:0] MAX_POS = 16'h7FFF;
  localparam logic [ANCHO_MEDIA-1:0] MIN_NEG = 16'h8000;

  // One buffered result: overflow flag plus the reduced halfword.
  typedef struct packed {
    logic                   ovf;
    logic [ANCHO_MEDIA-1:0] data;
  } entrada_t;

  // A word fits in signed 16 bits when bits [31:15] are all equal.
  function automatic logic cabe(input logic [ANCHO_PALABRA-1:0] w);
    return (&w[ANCHO_PALABRA-1:ANCHO_MEDIA-1]) || !(|w[ANCHO_PALABRA-1:ANCHO_MEDIA-1]);
  endfunction

endpackage

// File: rtl/fifo_reduccion.sv
// Generic synchronous FIFO; full/empty come from an occupancy counter.
// PROF must be a power of two so the pointers wrap naturally.
module fifo_reduccion #(
  parameter int PROF  = 2,
  parameter int ANCHO = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [ANCHO-1:0] wdata_i,
  input  logic             pop_i,
  output logic [ANCHO-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(PROF);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LLENO = CNT_W'(PROF);

  logic [ANCHO-1:0] mem_q [PROF];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == LLENO);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Next pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PROF; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/reduccion_signo.sv
// Narrowing unit: 32-bit signed words in, 16-bit halfwords plus overflow
// flag out through a small FIFO, with a saturating overflow counter.
// Build option REDUCCION_SATURA_EN: non-fitting words saturate to
// 7FFF/8000; otherwise they wrap to the low halfword.
module reduccion_signo
  import reduccion_pkg::*;
#(
  parameter int PROF      = 2,
  parameter int ANCHO_CNT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ANCHO_PALABRA-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ANCHO_MEDIA-1:0]   out_data,
  output logic                     out_ovf,
  input  logic                     clr_cnt,
  output logic [ANCHO_CNT-1:0]     ovf_cnt
);

  entrada_t             entrada, cabeza;
  logic                 acepta, saca, lleno, vacio;
  logic [ANCHO_CNT-1:0] cnt_q, cnt_d;

  assign in_ready  = !lleno;
  assign out_valid = !vacio;
  assign acepta    = in_valid && in_ready;
  assign saca      = out_valid && out_ready;
  assign out_data  = cabeza.data;
  assign out_ovf   = cabeza.ovf;
  assign ovf_cnt   = cnt_q;

  // Fit test and the saturate/wrap choice for words that do not fit.
  always_comb begin
    entrada.ovf  = !cabe(in_data);
    entrada.data = in_data[ANCHO_MEDIA-1:0];
`ifdef REDUCCION_SATURA_EN
    if (entrada.ovf) entrada.data = in_data[ANCHO_PALABRA-1] ? MIN_NEG : MAX_POS;
`else
    entrada.data = in_data[ANCHO_MEDIA-1:0];
`endif
  end

  // Overflow count: clear beats increment, and it sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) cnt_d = '0;
    else if (acepta && entrada.ovf && (cnt_q != '1)) cnt_d = cnt_q + ANCHO_CNT'(1);
  end

  // Overflow counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  fifo_reduccion #(
    .PROF  (PROF),
    .ANCHO ($bits(entrada_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (acepta),
    .wdata_i (entrada),
    .pop_i   (saca),
    .rdata_o (cabeza),
    .full_o  (lleno),
    .empty_o (vacio)
  );

endmodule

// File: tb/tb_reduccion_signo.sv
// Scoreboard bench for reduccion_signo (PROF=2, ANCHO_CNT=8).
module tb_reduccion_signo;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        clr_cnt;
  logic [7:0]  ovf_cnt;

  reduccion_signo #(.PROF(2), .ANCHO_CNT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .clr_cnt   (clr_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    logic        lat;
    longint      t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out actual=%h required=none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
        if (e.lat) chk("latency", 32'($time - e.t), 32'd5);
        n_out++;
      end
    end
  end

  // Present a word; leaves in_valid high so calls can run back to back.
  task automatic send(input logic [31:0] d, input logic [15:0] ed, input logic eo,
                      input logic lat, output int w);
    in_valid = 1'b1;
    in_data  = d;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept data=%h", d);
    end else begin
      @(posedge clk);
      sb.push_back('{ed, eo, lat, longint'($time)});
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] ov_pos, ov_neg;
  logic [15:0] e_pos, e_neg, e_8000, e_ffff7fff;
  int w, wsum;

  initial begin
    ov_pos = 32'h1234_5678;
    ov_neg = 32'h8000_0001;
`ifdef REDUCCION_SATURA_EN
    e_pos      = 16'h7FFF;
    e_neg      = 16'h8000;
    e_8000     = 16'h7FFF;
    e_ffff7fff = 16'h8000;
`else
    e_pos      = 16'h5678;
    e_neg      = 16'h0001;
    e_8000     = 16'h8000;
    e_ffff7fff = 16'h7FFF;
`endif
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Two fitting words, 1-cycle latency
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b1, w);
    send(32'h0000_7FFF, 16'h7FFF, 1'b0, 1'b1, w);
    idle(2);
    chk("cnt_after_fit", 32'(ovf_cnt), 32'd0);

    // Two boundary overflows
    send(32'h0000_8000, e_8000, 1'b1, 1'b1, w);
    send(32'hFFFF_7FFF, e_ffff7fff, 1'b1, 1'b1, w);
    chk("cnt_two_ovf", 32'(ovf_cnt), 32'd2);
    idle(2);

    // Backpressure: fill the 2-deep FIFO, third word held
    out_ready = 1'b0;
    send(32'h0000_0011, 16'h0011, 1'b0, 1'b0, w);
    send(32'hFFFF_FF22, 16'hFF22, 1'b0, 1'b0, w);
    in_data = 32'h0000_0033;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_in_ready", 32'(in_ready), 32'd0);
    chk("held_out_valid", 32'(out_valid), 32'd1);
    chk("held_out_data", 32'(out_data), 32'h0011);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_pop", 32'(in_ready), 32'd1);
    send(32'h0000_0033, 16'h0033, 1'b0, 1'b0, w);
    chk("third_wait", 32'(w), 32'd0);
    idle(3);
    chk("cnt_after_bp", 32'(ovf_cnt), 32'd2);

    // Streaming 20 words at full rate
    wsum = 0;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] d;
      d = (i % 2 == 1) ? (32'hFFFF_8000 + 32'(i)) : (32'h0000_1000 + 32'(i * 273));
      send(d, d[15:0], 1'b0, 1'b1, w);
      wsum += w;
    end
    chk("stream_waits", 32'(wsum), 32'd0);
    idle(3);
    chk("stream_outs", 32'(n_out), 32'd27);

    // 300 overflowing words: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 1) send(ov_neg, e_neg, 1'b1, 1'b1, w);
      else            send(ov_pos, e_pos, 1'b1, 1'b1, w);
      if (i == 251) chk("cnt_254", 32'(ovf_cnt), 32'd254);
      if (i == 252) chk("cnt_255", 32'(ovf_cnt), 32'd255);
    end
    chk("cnt_sat", 32'(ovf_cnt), 32'd255);
    clr_cnt = 1'b1;
    send(ov_pos, e_pos, 1'b1, 1'b1, w);
    clr_cnt = 1'b0;
    chk("clr_wins", 32'(ovf_cnt), 32'd0);
    send(ov_neg, e_neg, 1'b1, 1'b1, w);
    chk("cnt_after_clr", 32'(ovf_cnt), 32'd1);
    idle(3);

    // Reset mid-stream with two buffered entries
    out_ready = 1'b0;
    send(ov_pos, e_pos, 1'b1, 1'b0, w);
    send(ov_neg, e_neg, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    chk("pre_rst_cnt", 32'(ovf_cnt), 32'd3);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_ovf_cnt", 32'(ovf_cnt), 32'd0);
    sb.delete();
    @(posedge clk); #3;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    #1;
    send(32'h0000_0042, 16'h0042, 1'b0, 1'b1, w);
    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("total_outs", 32'(n_out), 32'd330);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
